// File: rtl/button_event_arbiter_if.sv
// Event-stream bundle between the button front end and the menu/entry consumer.
// The master modport is the consumer side. It drives the presses, acks and clears.
// The slave modport is the arbiter.
interface button_event_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   BtnPulse;
    logic           EvAck;
    logic           ClearOverrun;
    logic           EvValid;
    logic [IDW-1:0] EvId;
    logic [N-1:0]   Pending;
    logic [N-1:0]   Overrun;

    modport master (
        output BtnPulse, EvAck, ClearOverrun,
        input  EvValid, EvId, Pending, Overrun
    );

    modport slave (
        input  BtnPulse, EvAck, ClearOverrun,
        output EvValid, EvId, Pending, Overrun
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin serializer of button press pulses into a valid/ack event stream.
// Each button has a pending flag and a sticky overrun flag.
//
// state | meaning
// IDLE  | no offer; the next edge grants the first pending button after Last
// OFFER | EvValid=1, EvId held until the consumer acks
module button_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    button_event_arbiter_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t         state_q;
    logic           ev_valid_q;
    logic [IDW-1:0] ev_id_q;
    logic [IDW-1:0] last_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   overrun_q, overrun_d;
    logic           ack_fire;
    logic [N-1:0]   ack_clr;
    logic           found;
    logic [IDW-1:0] pick;

    assign bus.EvValid = ev_valid_q;
    assign bus.EvId    = ev_id_q;
    assign bus.Pending = pending_q;
    assign bus.Overrun = overrun_q;

    // An ack only counts while an offer is on the bus. It clears that button's
    // pending flag unless the same button presses again on this edge.
    always_comb begin
        ack_fire  = (state_q == OFFER) && bus.EvAck;
        ack_clr   = ack_fire ? (N'(1) << ev_id_q) : '0;
        pending_d = (pending_q & ~ack_clr) | bus.BtnPulse;
        overrun_d = (bus.ClearOverrun ? '0 : overrun_q)
                  | (bus.BtnPulse & pending_q & ~ack_clr);
    end

    // Round-robin search from Last+1 over the registered pending flags.
    // The scan runs from the far end back, so the nearest hit is the last one written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N; k >= 1; k--) begin
            if (pending_q[(int'(last_q) + k) % N]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_q) + k) % N);
            end
        end
    end

    // Pending and overrun flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Offer FSM with registered EvValid/EvId and the round-robin pointer.
    // After reset, Last=N-1 so that button 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            last_q     <= IDW'(N - 1);
        end else begin
            case (state_q)
                OFFER: begin
                    if (bus.EvAck) begin
                        last_q     <= ev_id_q;
                        ev_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    if (found) begin
                        ev_id_q    <= pick;
                        ev_valid_q <= 1'b1;
                        state_q    <= OFFER;
                    end else begin
                        ev_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter.
// A behavioural model tracks pending/overrun per button and the current offer.
// Directed scenarios pin known sequences, then a randomized run follows.
module tb_button_event_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    button_event_arbiter_if #(.N(N), .IDW(IDW)) bus_if ();

    button_event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    // Spec-level model: per-button flags, offer flag, offered id and last acked id.
    bit m_pend[N];
    bit m_ovr[N];
    bit m_offer;
    int m_id;
    int m_last;

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
            m_offer = 1'b0;
            m_id    = 0;
            m_last  = N - 1;
        end else begin
            bit ack;
            bit old_pend[N];
            ack = m_offer && bus_if.EvAck;
            for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
            if (!m_offer) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_offer && old_pend[(m_last + k) % N]) begin
                        m_offer = 1'b1;
                        m_id    = (m_last + k) % N;
                    end
                end
            end else if (ack) begin
                m_last  = m_id;
                m_offer = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                bit clr_i;
                clr_i     = ack && (m_id == i);
                m_ovr[i]  = (bus_if.BtnPulse[i] && old_pend[i] && !clr_i)
                         || (m_ovr[i] && !bus_if.ClearOverrun);
                m_pend[i] = (old_pend[i] && !clr_i) || bus_if.BtnPulse[i];
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_valid", int'(bus_if.EvValid), int'(m_offer));
            if (m_offer) check("mdl_id", int'(bus_if.EvId), m_id);
            check("mdl_pending", int'(bus_if.Pending), int'(pack(m_pend)));
            check("mdl_overrun", int'(bus_if.Overrun), int'(pack(m_ovr)));
        end
    end

    // Apply the inputs for one edge. Outputs are readable 1 time unit after it.
    task automatic cyc(input logic [N-1:0] p, input logic a, input logic c);
        bus_if.BtnPulse     = p;
        bus_if.EvAck        = a;
        bus_if.ClearOverrun = c;
        @(posedge clk);
        #1;
        bus_if.BtnPulse     = '0;
        bus_if.EvAck        = 1'b0;
        bus_if.ClearOverrun = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic serve(input int exp_id, input string nm);
        cyc('0, 1'b0, 1'b0);
        check({nm, "_valid"}, int'(bus_if.EvValid), 1);
        check({nm, "_id"}, int'(bus_if.EvId), exp_id);
        cyc('0, 1'b1, 1'b0);
        check({nm, "_drop"}, int'(bus_if.EvValid), 0);
    endtask

    initial begin
        bus_if.BtnPulse     = '0;
        bus_if.EvAck        = 1'b0;
        bus_if.ClearOverrun = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", int'(bus_if.EvValid), 0);
        check("rst_pending", int'(bus_if.Pending), 0);
        check("rst_overrun", int'(bus_if.Overrun), 0);
        check("rst_id", int'(bus_if.EvId), 0);

        // An ack in IDLE with nothing pending does nothing.
        cyc('0, 1'b1, 1'b0);
        check("idle_ack_valid", int'(bus_if.EvValid), 0);
        check("idle_ack_pend", int'(bus_if.Pending), 0);

        // A single press on button 2 is offered two edges after the pulse.
        cyc(4'b0100, 1'b0, 1'b0);
        check("b2_pend", int'(bus_if.Pending), 4'b0100);
        check("b2_valid_early", int'(bus_if.EvValid), 0);
        cyc('0, 1'b0, 1'b0);
        check("b2_valid", int'(bus_if.EvValid), 1);
        check("b2_id", int'(bus_if.EvId), 2);
        cyc('0, 1'b1, 1'b0);
        check("b2_ack_pend", int'(bus_if.Pending), 0);
        check("b2_ack_valid", int'(bus_if.EvValid), 0);

        // Buttons 0, 1 and 3 together after reset: served in order 0, 1, 3.
        do_reset();
        cyc(4'b1011, 1'b0, 1'b0);
        serve(0, "rr0");
        serve(1, "rr1");
        serve(3, "rr3");
        // Last=3, so with 0 and 3 both pending the order is 0, then 3.
        cyc(4'b1001, 1'b0, 1'b0);
        serve(0, "wrap0");
        serve(3, "wrap3");

        // A second press while the offer is held sets overrun.
        cyc(4'b0010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("ovr_offer_id", int'(bus_if.EvId), 1);
        cyc(4'b0010, 1'b0, 1'b0);
        check("ovr_flag", int'(bus_if.Overrun), 4'b0010);
        check("ovr_pend1", int'(bus_if.Pending[1]), 1);
        check("ovr_id_held", int'(bus_if.EvId), 1);
        check("ovr_valid_held", int'(bus_if.EvValid), 1);
        cyc('0, 1'b0, 1'b1);
        check("ovr_cleared", int'(bus_if.Overrun), 0);

        // A press on the same edge as its own ack is queued, with no overrun.
        cyc(4'b0010, 1'b1, 1'b0);
        check("reack_ovr", int'(bus_if.Overrun), 0);
        check("reack_pend", int'(bus_if.Pending), 4'b0010);
        check("reack_valid", int'(bus_if.EvValid), 0);
        serve(1, "reoffer");

        // An ack at the grant edge in IDLE is ignored and pending is kept.
        cyc(4'b0100, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0);
        check("grant_ack_pend", int'(bus_if.Pending), 4'b0100);
        check("grant_ack_valid", int'(bus_if.EvValid), 1);
        cyc('0, 1'b1, 1'b0);

        // Asynchronous reset during an offer with Pending=1010.
        cyc(4'b1010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("pre_rst_valid", int'(bus_if.EvValid), 1);
        check("pre_rst_pend", int'(bus_if.Pending), 4'b1010);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(bus_if.EvValid), 0);
        check("arst_id", int'(bus_if.EvId), 0);
        check("arst_pend", int'(bus_if.Pending), 0);
        check("arst_ovr", int'(bus_if.Overrun), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(4'b1000, 1'b0, 1'b0);
        check("post_rst_early", int'(bus_if.EvValid), 0);
        cyc('0, 1'b0, 1'b0);
        check("post_rst_valid", int'(bus_if.EvValid), 1);
        check("post_rst_id", int'(bus_if.EvId), 3);
        cyc('0, 1'b1, 1'b0);

        // Randomized traffic, checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] p;
            p = '0;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 5) == 0);
            cyc(p, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
